multi_chan_trig: RTL and testbench
==================================

# multi_chan_trig

Parametrised multi-channel trigger unit for the capture front end. Evaluates per-channel trigger terms (rising edge, falling edge, high level, low level, don't-care) on NUM_CH synchronised channel samples and ANDs them into one combined condition. A qualification counter requires the condition to hold for a programmable number of consecutive cycles. A small arm/trigger state machine issues a single trigger pulse and a sticky triggered flag to the capture controller.

## Interface
- NUM_CH, default 9: number of channels.
- CNT_W, default 8: width of the qualification counter and of match_cnt.

- clk  in  1: system clock; all state is on the rising edge.
- rst  in  1: asynchronous, active-high reset.
- armed  in  1: level; high = trigger search enabled, low = return to IDLE.
- ch_hi  in  NUM_CH: per-channel high-threshold samples, already synchronised to clk.
- ch_lo  in  NUM_CH: per-channel low-threshold samples, already synchronised to clk.
- cfg  in  5*NUM_CH: channel i uses cfg[5i+4:5i].
  - bit4 = rising edge of ch_hi.
  - bit3 = rising edge of ch_lo (signal fell).
  - bit2 = ch_hi level.
  - bit1 = ch_lo level.
  - bit0 = don't care.
- match_cnt  in  CNT_W: number of extra consecutive qualifying cycles required; 0 = fire on first.
- trig  out  1: one-cycle pulse on trigger.
- triggered  out  1: sticky; high in TRIGGERED.
- ch_hit  out  NUM_CH: registered per-channel term, for debug and status readback.
- state  out  2: encoded FSM state.

## Operation
- Per channel, the block registers s_hi and s_lo from ch_hi and ch_lo every cycle, in every state. It also holds the previous samples s_hi_d and s_lo_d.
- Edge detection:
  - edge_h = s_hi & ~s_hi_d.
  - edge_l = s_lo & ~s_lo_d.
  - Each edge has a sticky latch (lat_h, lat_l). A latch sets on its edge only while state == ARMED and clears in every other state.
- Channel term, evaluated combinationally:
  - term_i = (cfg4 & (edge_h | lat_h)) | (cfg3 & (edge_l | lat_l)) | (cfg2 & s_hi) | (cfg1 & s_lo) | cfg0.
- Combined condition: comb = AND over all term_i. If a channel has cfg = 0, comb is 0 and the block never triggers.
- FSM states (state encoding): IDLE = 0, ARMED = 1, TRIGGERED = 2. Encoding 3 is unused and recovers to IDLE.
- FSM transitions:
  - IDLE: go to ARMED when armed = 1.
  - ARMED: armed = 0 goes to IDLE.
  - ARMED: comb = 1 and qcnt == match_cnt goes to TRIGGERED and asserts trig for one cycle.
  - TRIGGERED: stays until armed = 0, then goes to IDLE.
- qcnt, width CNT_W:
  - Cleared outside ARMED.
  - In ARMED, increments while comb = 1 and resets to 0 when comb = 0.
  - Firing occurs before overflow, so no wrap is possible.
- Changing cfg or match_cnt takes effect on the next evaluation cycle. Software keeps them stable while armed; no protection is built in.

## Timing
- Reset values: state = IDLE, trig = 0, triggered = 0, ch_hit = 0, qcnt = 0, all sample registers and latches = 0.
- An input change at cycle n appears in s_* at n+1.
- For an edge or level event:
  - term_i and comb are true at n+1.
  - ch_hit is registered at n+2.
  - With match_cnt = 0, trig = 1 and triggered = 1 at n+2.
- Latency is identical for edge and level terms.
- With match_cnt = k, trig occurs k cycles later, provided comb stays 1 for k+1 consecutive cycles. Any comb = 0 cycle restarts the count.
- armed rising at cycle a gives state = ARMED at a+1. An edge whose s_hi rise occurs in any cycle ≥ a+1 counts.
- armed falling while ARMED: next state is IDLE, latches and qcnt clear, and no trig is issued in that transition cycle.
- armed falling while TRIGGERED: triggered drops the next cycle.
- A simultaneous fire condition and armed = 0: armed = 0 wins, giving IDLE with no trig.
- trig is never high for two consecutive cycles. Re-triggering requires armed to go low for at least one cycle.
- rst assertion clears everything immediately, regardless of clock.

## Structure
- Package trig_pkg holds:
  - the state enum typedef (IDLE, ARMED, TRIGGERED);
  - localparams for cfg bit indices (CFG_POS, CFG_NEG, CFG_HI, CFG_LO, CFG_DC);
  - CFG_W = 5.
- Sub-module chan_trig_slice: one instance per channel via generate. Contains the sample registers, previous-sample registers, edge latches and term_i. It takes clk, rst, a latch-enable (state == ARMED), s inputs and its cfg slice.
- Top level holds comb, qcnt, the FSM and the output registers.

## Test plan
- Rising edge, NUM_CH = 2: ch0 cfg = 5'b10000, ch1 cfg = 5'b00001, armed = 1, ch_hi[0] rises at cycle 10 -> trig = 1 only at cycle 12; triggered stays 1; state = 2.
- Level with qualification: ch0 cfg = 5'b00100, match_cnt = 3, ch_hi[0] high for 3 cycles then low, then high for 4 cycles -> no trig on the first burst; trig on the 4th cycle of the second burst plus 1.
- Sticky edge AND level: ch0 rising edge at cycle 5, ch1 high-level raised at cycle 20 -> trig at cycle 22, showing the latch held.
- Disarm mid-search: latch ch0 edge, drop armed, re-arm, raise ch1 level with no new ch0 edge -> no trig, because the latch was cleared.
- All cfg = 0: toggle all channels -> trig never asserts and state stays ARMED.
- Async reset mid-TRIGGERED: assert rst between clock edges -> state, triggered, trig and ch_hit are 0 immediately.

Source files
------------

// File: rtl/trig_pkg.sv
// rtl/trig_pkg.sv - shared state type and cfg field layout for the multi-channel trigger
package trig_pkg;

  // FSM encoding; value 3 is unused and steers back to IDLE
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    TRIGGERED = 2'd2
  } trig_state_t;

  // Per-channel cfg field: width and bit positions
  localparam int CFG_W   = 5;
  localparam int CFG_POS = 4;  // rising edge of ch_hi
  localparam int CFG_NEG = 3;  // rising edge of ch_lo (signal fell)
  localparam int CFG_HI  = 2;  // ch_hi level
  localparam int CFG_LO  = 1;  // ch_lo level
  localparam int CFG_DC  = 0;  // don't care

endpackage

// File: rtl/chan_trig_slice.sv
// rtl/chan_trig_slice.sv - one channel: sampling, edge detect, sticky edge latches, term
module chan_trig_slice
  import trig_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             lat_en,
  input  logic             hi,
  input  logic             lo,
  input  logic [CFG_W-1:0] cfg,
  output logic             term
);

  logic s_hi, s_lo, s_hi_d, s_lo_d;
  logic lat_h, lat_l;
  logic edge_h, edge_l;

  // Sample and previous-sample pipeline runs in every state so edges are never stale
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_hi   <= 1'b0;
      s_lo   <= 1'b0;
      s_hi_d <= 1'b0;
      s_lo_d <= 1'b0;
    end else begin
      s_hi   <= hi;
      s_lo   <= lo;
      s_hi_d <= s_hi;
      s_lo_d <= s_lo;
    end
  end

  assign edge_h = s_hi & ~s_hi_d;
  assign edge_l = s_lo & ~s_lo_d;

  // Edge latches accumulate only while the FSM is ARMED and drop in any other state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_h <= 1'b0;
      lat_l <= 1'b0;
    end else if (lat_en) begin
      lat_h <= lat_h | edge_h;
      lat_l <= lat_l | edge_l;
    end else begin
      lat_h <= 1'b0;
      lat_l <= 1'b0;
    end
  end

  // A cfg of all zeros yields term = 0, which blocks the AND in the top level
  assign term = (cfg[CFG_POS] & (edge_h | lat_h))
              | (cfg[CFG_NEG] & (edge_l | lat_l))
              | (cfg[CFG_HI]  & s_hi)
              | (cfg[CFG_LO]  & s_lo)
              |  cfg[CFG_DC];

endmodule

// File: rtl/multi_chan_trig.sv
// rtl/multi_chan_trig.sv - AND of channel terms, qualification counter and arm/trigger FSM
module multi_chan_trig
  import trig_pkg::*;
#(
  parameter int NUM_CH = 9,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    armed,
  input  logic [NUM_CH-1:0]       ch_hi,
  input  logic [NUM_CH-1:0]       ch_lo,
  input  logic [CFG_W*NUM_CH-1:0] cfg,
  input  logic [CNT_W-1:0]        match_cnt,
  output logic                    trig,
  output logic                    triggered,
  output logic [NUM_CH-1:0]       ch_hit,
  output logic [1:0]              state
);

  trig_state_t       state_q, state_d;
  logic [NUM_CH-1:0] term;
  logic [CNT_W-1:0]  qcnt;
  logic              comb;
  logic              fire;
  logic              lat_en;

  assign lat_en = (state_q == ARMED);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    chan_trig_slice u_slice (
      .clk    (clk),
      .rst    (rst),
      .lat_en (lat_en),
      .hi     (ch_hi[gi]),
      .lo     (ch_lo[gi]),
      .cfg    (cfg[CFG_W*gi +: CFG_W]),
      .term   (term[gi])
    );
  end

  assign comb = &term;

  // Next-state logic; disarm takes priority over a coincident fire condition
  always_comb begin
    state_d = state_q;
    fire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (armed) state_d = ARMED;
      end
      ARMED: begin
        if (!armed) begin
          state_d = IDLE;
        end else if (comb && (qcnt == match_cnt)) begin
          state_d = TRIGGERED;
          fire    = 1'b1;
        end
      end
      TRIGGERED: begin
        if (!armed) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counts consecutive qualifying cycles in ARMED; any gap or leaving ARMED restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qcnt <= '0;
    end else if ((state_q != ARMED) || !comb || fire) begin
      qcnt <= '0;
    end else begin
      qcnt <= qcnt + 1'b1;
    end
  end

  // State, trigger pulse and debug hit vector registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      trig    <= 1'b0;
      ch_hit  <= '0;
    end else begin
      state_q <= state_d;
      trig    <= fire;
      ch_hit  <= term;
    end
  end

  assign triggered = (state_q == TRIGGERED);
  assign state     = state_q;

endmodule

// File: tb/tb_multi_chan_trig.sv
// tb/tb_multi_chan_trig.sv - directed self-checking bench for multi_chan_trig
module tb_multi_chan_trig;

  logic       clk = 1'b0;
  logic       rst;
  logic       armed;
  logic [1:0] ch_hi;
  logic [1:0] ch_lo;
  logic [9:0] cfg;
  logic [7:0] match_cnt;
  logic       trig;
  logic       triggered;
  logic [1:0] ch_hit;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

  multi_chan_trig #(.NUM_CH(2), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .armed     (armed),
    .ch_hi     (ch_hi),
    .ch_lo     (ch_lo),
    .cfg       (cfg),
    .match_cnt (match_cnt),
    .trig      (trig),
    .triggered (triggered),
    .ch_hit    (ch_hit),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle;
    armed = 1'b0;
    ch_hi = 2'b00;
    ch_lo = 2'b00;
    repeat (3) tick();
  endtask

  task automatic test_reset;
    rst = 1'b1; armed = 1'b0; ch_hi = 2'b00; ch_lo = 2'b00; cfg = '0; match_cnt = '0;
    repeat (2) tick();
    if (state !== 2'd0) begin $display("FAIL reset_state: got %0d want 0", state); n_err++; end n_cmp++;
    if (trig !== 1'b0) begin $display("FAIL reset_trig: got %b want 0", trig); n_err++; end n_cmp++;
    if (triggered !== 1'b0) begin $display("FAIL reset_triggered: got %b want 0", triggered); n_err++; end n_cmp++;
    if (ch_hit !== 2'b00) begin $display("FAIL reset_ch_hit: got %b want 00", ch_hit); n_err++; end n_cmp++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_rising_edge;
    cfg = {5'b00001, 5'b10000}; match_cnt = 8'd0;
    armed = 1'b1;
    tick();
    if (state !== 2'd1) begin $display("FAIL edge_armed: got %0d want 1", state); n_err++; end n_cmp++;
    repeat (3) tick();
    ch_hi = 2'b01;
    tick();
    if (trig !== 1'b0) begin $display("FAIL edge_early: got %b want 0", trig); n_err++; end n_cmp++;
    if (ch_hit !== 2'b10) begin $display("FAIL edge_hit1: got %b want 10", ch_hit); n_err++; end n_cmp++;
    tick();
    if (trig !== 1'b1) begin $display("FAIL edge_trig: got %b want 1", trig); n_err++; end n_cmp++;
    if (triggered !== 1'b1) begin $display("FAIL edge_triggered: got %b want 1", triggered); n_err++; end n_cmp++;
    if (state !== 2'd2) begin $display("FAIL edge_state: got %0d want 2", state); n_err++; end n_cmp++;
    if (ch_hit !== 2'b11) begin $display("FAIL edge_hit2: got %b want 11", ch_hit); n_err++; end n_cmp++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (trig !== 1'b0) begin $display("FAIL edge_pulse_once %0d: got %b want 0", i, trig); n_err++; end n_cmp++;
      if (triggered !== 1'b1) begin $display("FAIL edge_sticky %0d: got %b want 1", i, triggered); n_err++; end n_cmp++;
    end
    armed = 1'b0;
    tick();
    if (state !== 2'd0) begin $display("FAIL edge_disarm_state: got %0d want 0", state); n_err++; end n_cmp++;
    if (triggered !== 1'b0) begin $display("FAIL edge_disarm_triggered: got %b want 0", triggered); n_err++; end n_cmp++;
    go_idle();
  endtask

  task automatic test_falling_edge;
    cfg = {5'b00001, 5'b01000}; match_cnt = 8'd0;
    armed = 1'b1;
    repeat (2) tick();
    ch_lo = 2'b01;
    tick();
    if (trig !== 1'b0) begin $display("FAIL fall_early: got %b want 0", trig); n_err++; end n_cmp++;
    tick();
    if (trig !== 1'b1) begin $display("FAIL fall_trig: got %b want 1", trig); n_err++; end n_cmp++;
    go_idle();
  endtask

  task automatic test_level_qual;
    logic exp_t;
    cfg = {5'b00001, 5'b00100}; match_cnt = 8'd3;
    armed = 1'b1;
    tick();
    ch_hi = 2'b01;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 3) ch_hi = 2'b00;
      if (trig !== 1'b0) begin $display("FAIL lvl_burst1 %0d: got %b want 0", i, trig); n_err++; end n_cmp++;
    end
    ch_hi = 2'b01;
    for (int i = 1; i <= 7; i++) begin
      tick();
      exp_t = (i == 5);
      if (trig !== exp_t) begin $display("FAIL lvl_burst2 %0d: got %b want %b", i, trig, exp_t); n_err++; end n_cmp++;
    end
    if (state !== 2'd2) begin $display("FAIL lvl_state: got %0d want 2", state); n_err++; end n_cmp++;
    go_idle();
    match_cnt = 8'd0;
  endtask

  task automatic test_sticky_edge;
    cfg = {5'b00100, 5'b10000}; match_cnt = 8'd0;
    armed = 1'b1;
    repeat (3) tick();
    ch_hi = 2'b01;
    repeat (2) tick();
    ch_hi = 2'b00;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (trig !== 1'b0) begin $display("FAIL sticky_wait %0d: got %b want 0", i, trig); n_err++; end n_cmp++;
    end
    ch_hi = 2'b10;
    tick();
    if (trig !== 1'b0) begin $display("FAIL sticky_early: got %b want 0", trig); n_err++; end n_cmp++;
    tick();
    if (trig !== 1'b1) begin $display("FAIL sticky_trig: got %b want 1", trig); n_err++; end n_cmp++;
    if (state !== 2'd2) begin $display("FAIL sticky_state: got %0d want 2", state); n_err++; end n_cmp++;
    go_idle();
  endtask

  task automatic test_disarm;
    cfg = {5'b00100, 5'b10000}; match_cnt = 8'd0;
    armed = 1'b1;
    tick();
    ch_hi = 2'b01;
    repeat (2) tick();
    ch_hi = 2'b00;
    armed = 1'b0;
    tick();
    if (state !== 2'd0) begin $display("FAIL disarm_state: got %0d want 0", state); n_err++; end n_cmp++;
    tick();
    armed = 1'b1;
    tick();
    ch_hi = 2'b10;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (trig !== 1'b0) begin $display("FAIL disarm_notrig %0d: got %b want 0", i, trig); n_err++; end n_cmp++;
    end
    if (state !== 2'd1) begin $display("FAIL disarm_rearm_state: got %0d want 1", state); n_err++; end n_cmp++;
    go_idle();
  endtask

  task automatic test_all_zero;
    logic [1:0] pat;
    cfg = '0; match_cnt = 8'd0;
    armed = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      pat = i[1:0];
      ch_hi = pat;
      ch_lo = ~pat;
      tick();
      if (trig !== 1'b0) begin $display("FAIL zero_trig %0d: got %b want 0", i, trig); n_err++; end n_cmp++;
      if (state !== 2'd1) begin $display("FAIL zero_state %0d: got %0d want 1", i, state); n_err++; end n_cmp++;
    end
    go_idle();
  endtask

  task automatic test_fire_vs_disarm;
    cfg = {5'b00001, 5'b00100}; match_cnt = 8'd0;
    armed = 1'b1;
    tick();
    ch_hi = 2'b01;
    tick();
    armed = 1'b0;
    tick();
    if (trig !== 1'b0) begin $display("FAIL race_trig: got %b want 0", trig); n_err++; end n_cmp++;
    if (state !== 2'd0) begin $display("FAIL race_state: got %0d want 0", state); n_err++; end n_cmp++;
    go_idle();
  endtask

  task automatic test_back_to_back;
    cfg = {5'b00001, 5'b00100}; match_cnt = 8'd0;
    ch_hi = 2'b01;
    repeat (2) tick();
    armed = 1'b1;
    tick();
    if (trig !== 1'b0) begin $display("FAIL b2b_arm_trig: got %b want 0", trig); n_err++; end n_cmp++;
    tick();
    if (trig !== 1'b1) begin $display("FAIL b2b_first: got %b want 1", trig); n_err++; end n_cmp++;
    tick();
    if (trig !== 1'b0) begin $display("FAIL b2b_no_repeat: got %b want 0", trig); n_err++; end n_cmp++;
    armed = 1'b0;
    tick();
    if (triggered !== 1'b0) begin $display("FAIL b2b_drop: got %b want 0", triggered); n_err++; end n_cmp++;
    armed = 1'b1;
    tick();
    if (state !== 2'd1) begin $display("FAIL b2b_rearm: got %0d want 1", state); n_err++; end n_cmp++;
    tick();
    if (trig !== 1'b1) begin $display("FAIL b2b_second: got %b want 1", trig); n_err++; end n_cmp++;
  endtask

  task automatic test_async_reset;
    if (state !== 2'd2) begin $display("FAIL arst_pre_state: got %0d want 2", state); n_err++; end n_cmp++;
    #2;
    rst = 1'b1;
    #1;
    if (state !== 2'd0) begin $display("FAIL arst_state: got %0d want 0", state); n_err++; end n_cmp++;
    if (triggered !== 1'b0) begin $display("FAIL arst_triggered: got %b want 0", triggered); n_err++; end n_cmp++;
    if (trig !== 1'b0) begin $display("FAIL arst_trig: got %b want 0", trig); n_err++; end n_cmp++;
    if (ch_hit !== 2'b00) begin $display("FAIL arst_ch_hit: got %b want 00", ch_hit); n_err++; end n_cmp++;
    tick();
    rst = 1'b0;
    go_idle();
  endtask

  initial begin
    test_reset();
    test_rising_edge();
    test_falling_edge();
    test_level_qual();
    test_sticky_edge();
    test_disarm();
    test_all_zero();
    test_fire_vs_disarm();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
